pc_fetch_ctrl: RTL and testbench

Fetch-stage PC sequencer for the pipelined RV32I core. Owns the architectural fetch PC register and drives the synchronous instruction-memory address. Arbitrates between sequential fetch, ID-stage JAL redirects and EX-stage branch/JALR redirects (encoded as the 2-bit PC-select code), and holds redirects that arrive during a pipeline stall. Generates IF/ID squash signals and the fetch-valid qualifier for the IF/ID register.

---
 rtl/pc_fetch_ctrl_pkg.sv | 16 +
 rtl/pc_fetch_ctrl_redirect_latch.sv | 39 +++
 rtl/pc_fetch_ctrl.sv | 113 +++++++++++
 tb/tb_pc_fetch_ctrl.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/pc_fetch_ctrl_pkg.sv
// pc_fetch_ctrl_pkg: PC-select encodings, fetch FSM states and reset PC shared by the fetch stage.
package pc_fetch_ctrl_pkg;

    localparam logic [1:0] PCSEL_SEQ = 2'b00;
    localparam logic [1:0] PCSEL_JAL = 2'b01;
    localparam logic [1:0] PCSEL_EX  = 2'b10;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h4000_0000;

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        RUN   = 2'd1,
        STALL = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/pc_fetch_ctrl_redirect_latch.sv
// pc_redirect_latch: holds one redirect (target + EX/JAL class) raised while fetch is stalled.
module pc_redirect_latch (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        capture_i,
    input  logic        is_ex_i,
    input  logic [31:0] target_i,
    input  logic        clear_i,
    output logic        pending_o,
    output logic        is_ex_o,
    output logic [31:0] target_o
);

    logic        pend_q, ex_q;
    logic [31:0] tgt_q;
    logic        load;

    // Only an older EX redirect may replace a pending JAL; everything else keeps the first one.
    assign load = capture_i && (!pend_q || (is_ex_i && !ex_q));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_q <= 1'b0;
            ex_q   <= 1'b0;
            tgt_q  <= 32'd0;
        end else if (load) begin
            pend_q <= 1'b1;
            ex_q   <= is_ex_i;
            tgt_q  <= target_i;
        end else if (clear_i) begin
            pend_q <= 1'b0;
        end
    end

    assign pending_o = pend_q;
    assign is_ex_o   = ex_q;
    assign target_o  = tgt_q;

endmodule

// File: rtl/pc_fetch_ctrl.sv
// pc_fetch_ctrl: fetch PC sequencer with JAL/EX redirects and stall-held redirects.
// Perf counters are built only when PC_FETCH_CTRL_PERF_EN is defined.
module pc_fetch_ctrl
    import pc_fetch_ctrl_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [1:0]  pc_sel,
    input  logic [31:0] jal_target,
    input  logic [31:0] ex_target,
    input  logic        stall,
    output logic [31:0] imem_addr,
    output logic [31:0] pc_if,
    output logic        fetch_valid,
    output logic        flush_if,
    output logic        flush_id,
    output logic        redirect_pending,
    output logic [31:0] redirect_cnt,
    output logic [31:0] flush_cnt
);

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic         fv_q, fv_d;
    logic         booting, advance, sel_ex, sel_jal;
    logic         pend, pend_ex;
    logic [31:0]  pend_tgt, jal_m, ex_m;

    assign jal_m   = {jal_target[31:1], 1'b0};
    assign ex_m    = {ex_target[31:1], 1'b0};
    assign sel_ex  = pc_sel == PCSEL_EX;
    assign sel_jal = pc_sel == PCSEL_JAL;
    assign booting = state_q == BOOT;
    assign advance = !booting && !stall;

    pc_redirect_latch u_latch (
        .clk       (clk),
        .rst_n     (rst_n),
        .capture_i (!booting && stall && (sel_ex || sel_jal)),
        .is_ex_i   (sel_ex),
        .target_i  (sel_ex ? ex_m : jal_m),
        .clear_i   (advance),
        .pending_o (pend),
        .is_ex_o   (pend_ex),
        .target_o  (pend_tgt)
    );

    always_comb begin
        imem_addr = pc_q + 32'd4;
        flush_if  = 1'b0;
        flush_id  = 1'b0;
        if (booting) begin
            imem_addr = RESET_PC;
        end else if (stall) begin
            imem_addr = pc_q;
        end else if (pend) begin
            imem_addr = pend_tgt;
            flush_if  = 1'b1;
            flush_id  = pend_ex;
        end else if (sel_ex) begin
            imem_addr = ex_m;
            flush_if  = 1'b1;
            flush_id  = 1'b1;
        end else if (sel_jal) begin
            imem_addr = jal_m;
            flush_if  = 1'b1;
        end
    end

    // imem_addr already equals pc_q while stalled and RESET_PC while booting.
    assign pc_d    = imem_addr;
    assign fv_d    = advance || booting ? 1'b1 : fv_q;
    assign state_d = booting ? RUN : (stall ? STALL : RUN);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= BOOT;
            pc_q    <= RESET_PC;
            fv_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            fv_q    <= fv_d;
        end
    end

`ifdef PC_FETCH_CTRL_PERF_EN
    logic [31:0] rcnt_q, fcnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rcnt_q <= 32'd0;
            fcnt_q <= 32'd0;
        end else begin
            rcnt_q <= rcnt_q + {31'd0, flush_if};
            fcnt_q <= fcnt_q + {31'd0, flush_if || flush_id};
        end
    end

    assign redirect_cnt = rcnt_q;
    assign flush_cnt    = fcnt_q;
`else
    assign redirect_cnt = 32'd0;
    assign flush_cnt    = 32'd0;
`endif

    assign pc_if            = pc_q;
    assign fetch_valid      = fv_q;
    assign redirect_pending = pend;

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// tb_pc_fetch_ctrl: directed self-checking bench for pc_fetch_ctrl.
module tb_pc_fetch_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [1:0]  pc_sel = 2'b00;
    logic [31:0] jal_target = 32'd0;
    logic [31:0] ex_target = 32'd0;
    logic        stall = 1'b0;
    logic [31:0] imem_addr, pc_if, redirect_cnt, flush_cnt;
    logic        fetch_valid, flush_if, flush_id, redirect_pending;

    int total = 0;
    int passed = 0;

`ifdef PC_FETCH_CTRL_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    pc_fetch_ctrl dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .pc_sel           (pc_sel),
        .jal_target       (jal_target),
        .ex_target        (ex_target),
        .stall            (stall),
        .imem_addr        (imem_addr),
        .pc_if            (pc_if),
        .fetch_valid      (fetch_valid),
        .flush_if         (flush_if),
        .flush_id         (flush_id),
        .redirect_pending (redirect_pending),
        .redirect_cnt     (redirect_cnt),
        .flush_cnt        (flush_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL timeout: got no finish, want finish");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) tick();
        total++; if (pc_if !== 32'h4000_0000) $display("FAIL rst_pc: got %h want %h", pc_if, 32'h4000_0000); else passed++;
        total++; if ({fetch_valid, flush_if, flush_id, redirect_pending} !== 4'b0) $display("FAIL rst_flags: got %b want 0000", {fetch_valid, flush_if, flush_id, redirect_pending}); else passed++;
        total++; if ({redirect_cnt, flush_cnt} !== 64'd0) $display("FAIL rst_cnt: got %h want 0", {redirect_cnt, flush_cnt}); else passed++;
        rst_n = 1'b1;
        #1;
        total++; if (imem_addr !== 32'h4000_0000) $display("FAIL boot_addr: got %h want %h", imem_addr, 32'h4000_0000); else passed++;
        total++; if (fetch_valid !== 1'b0) $display("FAIL boot_valid: got %b want 0", fetch_valid); else passed++;
        tick();
        total++; if (pc_if !== 32'h4000_0000 || fetch_valid !== 1'b1) $display("FAIL run0: got %h/%b want 40000000/1", pc_if, fetch_valid); else passed++;
        tick();
        total++; if (pc_if !== 32'h4000_0004) $display("FAIL run1: got %h want 40000004", pc_if); else passed++;
        tick();
        total++; if (pc_if !== 32'h4000_0008) $display("FAIL run2: got %h want 40000008", pc_if); else passed++;
    endtask

    task automatic test_ex_redirect();
        pc_sel = 2'b10; ex_target = 32'h4000_0101;
        #1;
        total++; if (imem_addr !== 32'h4000_0100) $display("FAIL ex_addr: got %h want 40000100", imem_addr); else passed++;
        total++; if ({flush_if, flush_id} !== 2'b11) $display("FAIL ex_flush: got %b want 11", {flush_if, flush_id}); else passed++;
        tick();
        pc_sel = 2'b00;
        #1;
        total++; if (pc_if !== 32'h4000_0100 || fetch_valid !== 1'b1) $display("FAIL ex_pc: got %h/%b want 40000100/1", pc_if, fetch_valid); else passed++;
        total++; if ({flush_if, flush_id} !== 2'b00) $display("FAIL ex_noflush: got %b want 00", {flush_if, flush_id}); else passed++;
    endtask

    task automatic test_jal_redirect();
        pc_sel = 2'b01; jal_target = 32'h4000_0200;
        #1;
        total++; if (imem_addr !== 32'h4000_0200) $display("FAIL jal_addr: got %h want 40000200", imem_addr); else passed++;
        total++; if ({flush_if, flush_id} !== 2'b10) $display("FAIL jal_flush: got %b want 10", {flush_if, flush_id}); else passed++;
        tick();
        pc_sel = 2'b00;
        #1;
        total++; if (pc_if !== 32'h4000_0200) $display("FAIL jal_pc: got %h want 40000200", pc_if); else passed++;
        total++; if (redirect_cnt !== (PERF ? 32'd2 : 32'd0)) $display("FAIL rcnt2: got %0d want %0d", redirect_cnt, PERF ? 2 : 0); else passed++;
        total++; if (flush_cnt !== (PERF ? 32'd2 : 32'd0)) $display("FAIL fcnt2: got %0d want %0d", flush_cnt, PERF ? 2 : 0); else passed++;
    endtask

    task automatic test_stall_pending();
        stall = 1'b1; pc_sel = 2'b01; jal_target = 32'h4000_0300;
        #1;
        total++; if (imem_addr !== 32'h4000_0200 || flush_if !== 1'b0) $display("FAIL stall_refetch: got %h/%b want 40000200/0", imem_addr, flush_if); else passed++;
        tick();
        pc_sel = 2'b10; ex_target = 32'h4000_0400;
        #1;
        total++; if (redirect_pending !== 1'b1 || pc_if !== 32'h4000_0200) $display("FAIL stall_pend1: got %b/%h want 1/40000200", redirect_pending, pc_if); else passed++;
        tick();
        pc_sel = 2'b01; jal_target = 32'h4000_0500;
        #1;
        total++; if (redirect_pending !== 1'b1 || pc_if !== 32'h4000_0200) $display("FAIL stall_pend2: got %b/%h want 1/40000200", redirect_pending, pc_if); else passed++;
        tick();
        stall = 1'b0; pc_sel = 2'b00;
        #1;
        total++; if (imem_addr !== 32'h4000_0400) $display("FAIL release_addr: got %h want 40000400", imem_addr); else passed++;
        total++; if ({flush_if, flush_id} !== 2'b11) $display("FAIL release_flush: got %b want 11", {flush_if, flush_id}); else passed++;
        tick();
        total++; if (redirect_pending !== 1'b0 || pc_if !== 32'h4000_0400) $display("FAIL release_pc: got %b/%h want 0/40000400", redirect_pending, pc_if); else passed++;
        total++; if (redirect_cnt !== (PERF ? 32'd3 : 32'd0)) $display("FAIL rcnt3: got %0d want %0d", redirect_cnt, PERF ? 3 : 0); else passed++;
    endtask

    task automatic test_wrap_and_align();
        pc_sel = 2'b11;
        #1;
        total++; if (imem_addr !== 32'h4000_0404 || flush_if !== 1'b0) $display("FAIL reserved_sel: got %h/%b want 40000404/0", imem_addr, flush_if); else passed++;
        pc_sel = 2'b10; ex_target = 32'hFFFF_FFFD;
        tick();
        pc_sel = 2'b00;
        #1;
        total++; if (pc_if !== 32'hFFFF_FFFC || imem_addr !== 32'h0000_0000) $display("FAIL wrap_addr: got %h/%h want fffffffc/00000000", pc_if, imem_addr); else passed++;
        tick();
        total++; if (pc_if !== 32'h0000_0000) $display("FAIL wrap_pc: got %h want 00000000", pc_if); else passed++;
        pc_sel = 2'b01; jal_target = 32'h0000_0013;
        #1;
        total++; if (imem_addr !== 32'h0000_0012) $display("FAIL bit_align: got %h want 00000012", imem_addr); else passed++;
        tick();
        pc_sel = 2'b00;
    endtask

    task automatic test_reset_pending();
        stall = 1'b1; pc_sel = 2'b10; ex_target = 32'h4000_0800;
        tick();
        pc_sel = 2'b00;
        total++; if (redirect_pending !== 1'b1) $display("FAIL pre_rst_pend: got %b want 1", redirect_pending); else passed++;
        rst_n = 1'b0;
        #1;
        total++; if (pc_if !== 32'h4000_0000 || redirect_pending !== 1'b0 || fetch_valid !== 1'b0) $display("FAIL async_rst: got %h/%b/%b want 40000000/0/0", pc_if, redirect_pending, fetch_valid); else passed++;
        total++; if ({redirect_cnt, flush_cnt} !== 64'd0) $display("FAIL async_rst_cnt: got %h want 0", {redirect_cnt, flush_cnt}); else passed++;
        tick();
        stall = 1'b0;
        rst_n = 1'b1;
        #1;
        total++; if (imem_addr !== 32'h4000_0000 || flush_if !== 1'b0) $display("FAIL reboot_addr: got %h/%b want 40000000/0", imem_addr, flush_if); else passed++;
        tick();
        tick();
        total++; if (pc_if !== 32'h4000_0004 || flush_if !== 1'b0) $display("FAIL reboot_seq: got %h/%b want 40000004/0", pc_if, flush_if); else passed++;
    endtask

    initial begin
        test_reset();
        test_ex_redirect();
        test_jal_redirect();
        test_stall_pending();
        test_wrap_and_align();
        test_reset_pending();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
